// File: rtl/zero_scan_pkg.sv
// Shared definitions for the zero_scan block: controller state encoding and
// width helpers used to size the count and index registers.
package zero_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to hold any value in 0..width inclusive.
  function automatic int unsigned cw_bits(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  // Bits needed to index n items; never less than one.
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/zero_scan_chunk_zc.sv
// chunk_zc: combinational zero counter for a single CHUNK-bit slice.
// Ports:
//   chunk      - slice under examination
//   mode       - 0 = count leading zeros, 1 = count trailing zeros
//   all_zero_c - slice is entirely zero
//   zc_c       - zero count in the selected direction (CHUNK when all zero)
module chunk_zc
  import zero_scan_pkg::*;
#(
  parameter int unsigned CHUNK = 8,
  localparam int unsigned ZW = cw_bits(CHUNK)
) (
  input  logic [CHUNK-1:0] chunk,
  input  logic             mode,
  output logic             all_zero_c,
  output logic [ZW-1:0]    zc_c
);

  // Last match in loop order wins, so iterate toward the bit that must dominate.
  always_comb begin
    all_zero_c = (chunk == '0);
    zc_c       = ZW'(CHUNK);
    if (!mode) begin
      for (int unsigned i = 0; i < CHUNK; i++) begin
        if (chunk[i]) zc_c = ZW'(CHUNK - 1 - i);
      end
    end else begin
      for (int i = int'(CHUNK) - 1; i >= 0; i--) begin
        if (chunk[i]) zc_c = ZW'(i);
      end
    end
  end

endmodule

// File: rtl/zero_scan.sv
// zero_scan: multi-cycle leading/trailing zero counter that examines one
// CHUNK-bit slice of the captured operand per clock.
// Ports:
//   clk, rst   - clock and asynchronous active-high reset
//   in_valid   - operand offered;  in_ready - block idle and accepting
//   value      - operand;          mode     - 0 = leading, 1 = trailing zeros
//   out_valid  - result presented; out_ready - consumer takes the result
//   zero_flag  - operand was all zeros
//   zcount     - zero count (WIDTH when zero_flag is set)
module zero_scan
  import zero_scan_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned CHUNK      = 8,
  parameter bit          EARLY_EXIT = 1'b1,
  localparam int unsigned CW = cw_bits(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] value,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             zero_flag,
  output logic [CW-1:0]    zcount
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned KW     = idx_bits(NCHUNK);
  localparam int unsigned ZW     = cw_bits(CHUNK);

  state_t           state;
  logic [WIDTH-1:0] value_q;
  logic             mode_q;
  logic [KW-1:0]    k;
  logic [CW-1:0]    acc;
  logic             found;

  logic [KW-1:0]    sel_c;
  logic [CHUNK-1:0] chunk_c;
  logic             chunk_zero_c;
  logic [ZW-1:0]    chunk_zc_c;
  logic             found_nx_c;
  logic [CW-1:0]    acc_nx_c;
  logic             last_c;

  // Chunk select: leading-zero scans walk down from the MSB slice.
  always_comb begin
    sel_c   = mode_q ? k : (KW'(NCHUNK - 1) - k);
    chunk_c = '0;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (sel_c == KW'(i)) chunk_c = value_q[i*CHUNK +: CHUNK];
    end
  end

  chunk_zc #(.CHUNK(CHUNK)) u_chunk_zc (
    .chunk      (chunk_c),
    .mode       (mode_q),
    .all_zero_c (chunk_zero_c),
    .zc_c       (chunk_zc_c)
  );

  // Accumulator freezes once the first set bit has been counted.
  always_comb begin
    found_nx_c = found | ~chunk_zero_c;
    acc_nx_c   = acc;
    if (!found) begin
      acc_nx_c = acc + (chunk_zero_c ? CW'(CHUNK) : CW'(chunk_zc_c));
    end
    last_c = (k == KW'(NCHUNK - 1));
  end

  // Controller and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      zero_flag <= 1'b0;
      zcount    <= '0;
      value_q   <= '0;
      mode_q    <= 1'b0;
      k         <= '0;
      acc       <= '0;
      found     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            value_q  <= value;
            mode_q   <= mode;
            k        <= '0;
            acc      <= '0;
            found    <= 1'b0;
            in_ready <= 1'b0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          acc   <= acc_nx_c;
          found <= found_nx_c;
          k     <= k + KW'(1);
          if ((found_nx_c && EARLY_EXIT) || last_c) begin
            out_valid <= 1'b1;
            zcount    <= acc_nx_c;
            zero_flag <= ~found_nx_c;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zero_scan.sv
// Scoreboard bench for zero_scan: one early-exit and one fixed-latency instance
// share stimulus; a monitor checks each result against a bit-level model.
module tb_zero_scan;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned CHUNK  = 8;
  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CW     = 6;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic [WIDTH-1:0] value;
  logic mode;
  logic out_ready;

  logic          in_ready_w  [2];
  logic          out_valid_w [2];
  logic          zero_flag_w [2];
  logic [CW-1:0] zcount_w    [2];

  always #5 clk = ~clk;

  zero_scan #(.WIDTH(WIDTH), .CHUNK(CHUNK), .EARLY_EXIT(1'b1)) dut_ee (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .value(value), .mode(mode), .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .zero_flag(zero_flag_w[0]), .zcount(zcount_w[0]));

  zero_scan #(.WIDTH(WIDTH), .CHUNK(CHUNK), .EARLY_EXIT(1'b0)) dut_fx (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .value(value), .mode(mode), .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .zero_flag(zero_flag_w[1]), .zcount(zcount_w[1]));

  typedef struct {
    int zc;
    bit zf;
    int lat_ee;
    int acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   rd_idx [2];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   hold = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: count zero bits from the chosen end; latency follows from
  // which chunk holds the first set bit.
  function automatic exp_t model(input logic [WIDTH-1:0] v, input logic m, input int acc_cyc);
    exp_t e;
    e.zc = 0;
    if (!m) begin
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        if (v[i]) break;
        e.zc++;
      end
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (v[i]) break;
        e.zc++;
      end
    end
    e.zf      = (v == '0);
    e.lat_ee  = e.zf ? int'(NCHUNK) : (e.zc / int'(CHUNK) + 1);
    e.acc_cyc = acc_cyc;
    return e;
  endfunction

  task automatic chk(input string name, input int d, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d, expected %0d (cycle %0d)", name, d, act, exp, cyc);
    end
  endtask

  // Monitor: compares every new result and checks hold/release behaviour.
  bit   prev_v  [2];
  bit   prev_hs [2];
  int   held_zc [2];
  bit   held_zf [2];
  exp_t mon_e;

  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          prev_v[d]  = 1'b0;
          prev_hs[d] = 1'b0;
        end else begin
          if (prev_hs[d]) begin
            chk("release_in_ready", d, int'(in_ready_w[d]), 1);
            chk("release_out_valid", d, int'(out_valid_w[d]), 0);
          end
          if (out_valid_w[d]) begin
            if (!prev_v[d]) begin
              if (rd_idx[d] >= exp_q.size()) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result dut%0d: got zcount=%0d, expected no output", d, zcount_w[d]);
              end else begin
                mon_e = exp_q[rd_idx[d]];
                rd_idx[d]++;
                chk("zcount", d, int'(zcount_w[d]), mon_e.zc);
                chk("zero_flag", d, int'(zero_flag_w[d]), int'(mon_e.zf));
                chk("latency", d, cyc - mon_e.acc_cyc, (d == 0) ? mon_e.lat_ee : int'(NCHUNK));
                chk("busy_in_ready", d, int'(in_ready_w[d]), 0);
              end
              held_zc[d] = int'(zcount_w[d]);
              held_zf[d] = zero_flag_w[d];
            end else begin
              chk("hold_zcount", d, int'(zcount_w[d]), held_zc[d]);
              chk("hold_zero_flag", d, int'(zero_flag_w[d]), int'(held_zf[d]));
              chk("hold_in_ready", d, int'(in_ready_w[d]), 0);
            end
          end
          prev_v[d]  = out_valid_w[d];
          prev_hs[d] = out_valid_w[d] && out_ready;
        end
      end
    end
  end

  // Consumer: random backpressure, with a forced stall window on request.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold > 0) begin
        out_ready = 1'b0;
        hold--;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (in_ready_w[0] || in_ready_w[1]) in_valid = 1'b0;
  endtask

  // Offer an operand for exactly the accept edge, then drive ignored junk.
  task automatic issue(input logic [WIDTH-1:0] v, input logic m);
    int w;
    w = 0;
    while (!(in_ready_w[0] && in_ready_w[1])) begin
      step();
      w++;
      if (w > 300) begin
        n_tests++;
        n_fail++;
        $display("FAIL ready_timeout: in_ready still low after %0d cycles, expected 1", w);
        return;
      end
    end
    in_valid = 1'b1;
    value    = v;
    mode     = m;
    exp_q.push_back(model(v, m, cyc + 1));
    @(posedge clk);
    #1;
    in_valid = 1'($urandom_range(0, 1));
    value    = $urandom;
    mode     = 1'($urandom_range(0, 1));
  endtask

  function automatic logic [WIDTH-1:0] rand_value();
    logic [WIDTH-1:0] v;
    case ($urandom_range(0, 3))
      0:       v = $urandom;
      1:       v = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
      2:       v = $urandom >> $urandom_range(0, WIDTH - 1);
      default: v = ($urandom_range(0, 4) == 0) ? '0 : ($urandom << $urandom_range(0, WIDTH - 1));
    endcase
    return v;
  endfunction

  initial begin
    int w;
    rst       = 1'b1;
    in_valid  = 1'b0;
    value     = '0;
    mode      = 1'b0;
    rd_idx[0] = 0;
    rd_idx[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_out_valid", d, int'(out_valid_w[d]), 0);
      chk("reset_zero_flag", d, int'(zero_flag_w[d]), 0);
      chk("reset_zcount", d, int'(zcount_w[d]), 0);
      chk("reset_in_ready", d, int'(in_ready_w[d]), 1);
    end
    rst  = 1'b0;
    hold = 8;

    issue(32'h8000_0000, 1'b0);
    issue(32'h0001_0000, 1'b0);
    issue(32'h0001_0000, 1'b1);
    issue(32'h0000_0000, 1'b0);
    issue(32'h0000_0000, 1'b1);
    issue(32'h0000_0001, 1'b0);
    issue(32'h0000_0001, 1'b1);
    issue(32'hFFFF_FFFF, 1'b0);

    // Abort an all-zero scan partway through.
    issue(32'h0000_0000, 1'b0);
    step();
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("abort_out_valid", d, int'(out_valid_w[d]), 0);
      chk("abort_in_ready", d, int'(in_ready_w[d]), 1);
    end
    exp_q.delete();
    rd_idx[0] = 0;
    rd_idx[1] = 0;
    in_valid  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    for (int d = 0; d < 2; d++) begin
      chk("post_reset_in_ready", d, int'(in_ready_w[d]), 1);
      chk("post_reset_out_valid", d, int'(out_valid_w[d]), 0);
    end
    issue(32'h0001_0000, 1'b1);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
      issue(rand_value(), 1'($urandom_range(0, 1)));
    end

    w = 0;
    while ((rd_idx[0] < exp_q.size() || rd_idx[1] < exp_q.size()) && w < 500) begin
      step();
      w++;
    end
    if (w >= 500) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: results outstanding %0d/%0d, expected 0/0",
               exp_q.size() - rd_idx[0], exp_q.size() - rd_idx[1]);
    end
    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/zero_scan.md
ZERO_SCAN -- requirements
Module: zero_scan

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; SHALL be a positive multiple of CHUNK.
REQ-002 Parameter CHUNK, default 8, number of bits examined per scan cycle; SHALL divide WIDTH.
REQ-003 Parameter EARLY_EXIT, default 1; 1 ends the scan at the first nonzero chunk, 0 gives a fixed latency of WIDTH/CHUNK cycles.
REQ-004 Derived constants: NCHUNK = WIDTH/CHUNK; CW = clog2(WIDTH+1).
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  operand offered.
REQ-008 in_ready  output  1  block can accept an operand.
REQ-009 value  input  WIDTH  operand to scan.
REQ-010 mode  input  1  0 = count leading zeros (scan from MSB chunk), 1 = count trailing zeros (scan from LSB chunk).
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 zero_flag  output  1  captured operand was all zeros.
REQ-014 zcount  output  CW  leading or trailing zero count, per the captured mode.

Function
REQ-015 States: IDLE, SCAN, DONE. in_ready SHALL be 1 exactly when the state is IDLE.
REQ-016 Accept occurs on an edge where in_valid & in_ready; value and mode are registered and the state goes to SCAN with chunk index k=0 and accumulator 0. Input changes after accept SHALL have no effect.
REQ-017 In SCAN, chunk k SHALL be examined each cycle: the MSB-side k-th chunk for mode 0, or the LSB-side k-th chunk for mode 1.
REQ-018 All-zero chunk: accumulator += CHUNK.
REQ-019 Nonzero chunk: accumulator += the in-chunk zero count in the scan direction, and a found bit is set. Later chunks SHALL NOT modify the accumulator.
REQ-020 Terminate on the edge that ends examination of chunk k when (found && EARLY_EXIT) or k = NCHUNK-1; the block goes to DONE with out_valid=1, zcount=accumulator, zero_flag = ~found.
REQ-021 Latency from accept edge to out_valid: k+1 edges with EARLY_EXIT=1, where k is the terminating chunk; always NCHUNK edges with EARLY_EXIT=0.
REQ-022 In DONE, outputs SHALL hold stable while out_ready=0; on an edge with out_ready=1 the block goes to IDLE and out_valid drops to 0.
REQ-023 zcount SHALL equal WIDTH if and only if zero_flag=1; otherwise 0 <= zcount <= WIDTH-1. No overflow is possible with CW bits.
REQ-024 in_valid asserted during SCAN or DONE SHALL be ignored; the source holds the operand until in_ready.
REQ-025 zcount and zero_flag SHALL be registered outputs. They hold their last values in IDLE and are meaningful only while out_valid=1.

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, out_valid=0, zero_flag=0, zcount=0, accumulator=0, k=0, found=0.
REQ-027 Reset during SCAN or DONE SHALL abort the operation with no result produced. in_ready SHALL be 1 on the first edge after rst deasserts.

Structure
REQ-028 Package zero_scan_pkg SHALL hold the state encoding (IDLE/SCAN/DONE) and the clog2-based CW helper function.
REQ-029 Sub-module chunk_zc (combinational, parameter CHUNK) SHALL return the all-zero indication and the leading/trailing zero count of one chunk, selected by mode. It is instantiated once, and the chunk mux feeds it.
REQ-030 The datapath SHALL be sized from WIDTH/CHUNK only, with no hard-coded 32.

Verification (WIDTH=32, CHUNK=8)
REQ-031 EARLY_EXIT=1, mode 0, value 0x80000000 -> out_valid 1 edge after accept, zcount=0, zero_flag=0.
REQ-032 EARLY_EXIT=1, mode 0, value 0x00010000 -> out_valid after 2 edges, zcount=15; the same value with mode 1 -> 3 edges, zcount=16.
REQ-033 value 0x00000000, either mode -> out_valid after 4 edges, zcount=32, zero_flag=1; value 0x00000001, mode 0 -> 4 edges, zcount=31.
REQ-034 EARLY_EXIT=0, value 0x80000000 -> out_valid after exactly 4 edges, zcount=0.
REQ-035 out_ready held 0 for 5 cycles in DONE -> outputs stable and in_ready=0 throughout; back-to-back operands are accepted one edge after out_ready.
REQ-036 rst pulsed mid-SCAN -> out_valid never asserts for that operand; in_ready=1 after release, and the next operand scans correctly.
